// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings, PC-source constants and hazard helper
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } state_t;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  // r0 never carries a real dependency, and rt only matters when ID reads it
  function automatic logic load_use(input logic ex_memread, input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs, input logic [4:0] id_rt,
                                    input logic id_uses_rt);
    return ex_memread && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts MEM_WAIT cycles and latches a sticky watchdog error
module mem_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit,
  output logic mem_timeout
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  assign hit = wait_cnt_q == W'(TIMEOUT - 1);
  assign mem_timeout = mem_timeout_q;
  // clear on entry to a wait, count each unready wait cycle, latch error on the last one
  always_comb begin
    wait_cnt_d = clr ? '0 : en ? wait_cnt_q + 1'b1 : wait_cnt_q;
    mem_timeout_d = mem_timeout_q | (en & hit);
  end
  // watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for stalls, bubbles, flushes and memory freeze
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       pc_src_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic tmr_clr, tmr_en, tmr_hit;
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(CLK), .rst(RST), .clr(tmr_clr), .en(tmr_en), .hit(tmr_hit), .mem_timeout(mem_timeout)
  );
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  // prioritised hazard decisions; an unready wait keeps the freeze, a ready one falls through to RUN rules
  always_comb begin
    pc_write = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold = 1'b0;
    pc_src_sel = PCSRC_SEQ;
    state_d = RUN;
    tmr_clr = 1'b0;
    tmr_en = 1'b0;
    if (state_q == TRAP) begin
      {pc_write, ifid_write, pipe_hold, idex_bubble} = 4'b0011;
      state_d = TRAP;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      {pc_write, ifid_write, pipe_hold} = 3'b001;
      tmr_en = 1'b1;
      state_d = tmr_hit ? TRAP : MEM_WAIT;
    end else if (mem_req && !mem_ready) begin
      {pc_write, ifid_write, pipe_hold} = 3'b001;
      tmr_clr = 1'b1;
      state_d = MEM_WAIT;
    end else if (load_use(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt)) begin
      {pc_write, ifid_write, idex_bubble} = 3'b001;
      state_d = LU_STALL;
    end else if (id_jump) begin
      pc_src_sel = PCSRC_JMP;
      ifid_flush = 1'b1;
    end else if (id_branch_taken) begin
      pc_src_sel = PCSRC_BR;
      ifid_flush = 1'b1;
    end
    if (RST) begin
      {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold} = '0;
      pc_src_sel = PCSRC_SEQ;
    end
    stall_cnt_d = (!pc_write && state_q != TRAP && ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (ifid_flush && ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  // state and saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a behavioural sequencer model
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  localparam int OW = 8 + 2 * CNT_W;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 0, id_branch_taken = 0, id_jump = 0, ex_memread = 0, mem_req = 0, mem_ready = 0;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
  logic [1:0] pc_src_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int compared = 0, mismatched = 0;
  bit m_wait, m_trap, m_to;
  int m_waited, m_stall, m_flush;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken), .id_jump(id_jump), .ex_rt(ex_rt), .ex_memread(ex_memread),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .pc_src_sel(pc_src_sel), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] observed();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, pc_src_sel, mem_timeout, stall_cnt, flush_cnt};
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] exp);
    logic [OW-1:0] obs;
    obs = observed();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (pcw,ifw,flush,bub,hold,sel,to,stall,flush)", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    {id_rs, id_rt, ex_rt, id_uses_rt, id_branch_taken, id_jump, ex_memread, mem_req, mem_ready} = '0;
    rst = 1'b1;
    #1 check(tag, '0);
    {m_wait, m_trap, m_to} = '0;
    m_waited = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one clock cycle: drive, compare against the model, then advance the model past the next edge
  task automatic step(input string tag, input logic [4:0] rs, rt, input logic ut, bt, j,
                      input logic [4:0] ert, input logic emr, mr, mrdy);
    logic pcw, ifw, fl, bub, hold, lu, cur_trap;
    logic [1:0] sel;
    @(posedge clk);
    #1;
    {id_rs, id_rt, id_uses_rt, id_branch_taken, id_jump, ex_rt, ex_memread, mem_req, mem_ready} =
      {rs, rt, ut, bt, j, ert, emr, mr, mrdy};
    #3;
    lu = emr && ert != 0 && (ert == rs || (ut && ert == rt));
    {pcw, ifw, fl, bub, hold, sel} = 7'b1100000;
    cur_trap = m_trap;
    if (m_trap) {pcw, ifw, hold, bub} = 4'b0011;
    else if (m_wait && !mrdy) begin
      {pcw, ifw, hold} = 3'b001;
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_trap = 1; m_wait = 0;
      end
    end else if (mr && !mrdy) begin
      {pcw, ifw, hold} = 3'b001;
      m_wait = 1; m_waited = 0;
    end else begin
      m_wait = 0;
      if (lu) {pcw, ifw, bub} = 3'b001;
      else if (j) {sel, fl} = 3'b101;
      else if (bt) {sel, fl} = 3'b011;
    end
    check(tag, {pcw, ifw, fl, bub, hold, sel, m_to, CNT_W'(m_stall), CNT_W'(m_flush)});
    if (!pcw && !cur_trap && m_stall < SAT) m_stall++;
    if (fl && m_flush < SAT) m_flush++;
    if (m_trap) m_to = 1;
  endtask

  initial begin
    do_reset("reset");
    step("lu_stall", 5, 0, 0, 0, 0, 5, 1, 0, 0);
    step("lu_release", 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r0_no_stall", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("rt_unused", 1, 7, 0, 0, 0, 7, 1, 0, 0);
    step("rt_used", 1, 7, 1, 0, 0, 7, 1, 0, 0);
    step("br_behind_load", 5, 0, 0, 1, 0, 5, 1, 0, 0);
    step("br_resolves", 5, 0, 0, 1, 0, 0, 0, 0, 0);
    step("jump", 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step("after_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset("reset_mw");
    for (int i = 0; i < 3; i++) step("mw_freeze", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_ready", 0, 0, 0, 1, 0, 0, 0, 1, 1);
    step("mw_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    assert (stall_cnt === CNT_W'(3)) else begin
      mismatched++;
      $error("FAIL mw_stall_cnt: observed %0d expected 3", stall_cnt);
    end
    compared++;
    step("zero_wait_lu", 5, 0, 0, 0, 0, 5, 1, 1, 1);
    step("mw_lu_on_ready_a", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_lu_on_ready_b", 3, 0, 0, 0, 0, 3, 1, 1, 1);
    step("mw_lu_on_ready_c", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("mw_pre_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset("reset_mid_wait");
    for (int i = 0; i < 8; i++) step("watchdog", 0, 0, 0, 1, 0, 5, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("trap_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset("reset_trap");
    for (int i = 0; i < 20; i++) step("sat_lu", 9, 0, 0, 0, 0, 9, 1, 0, 0);
    step("sat_end", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    assert (stall_cnt === CNT_W'(SAT)) else begin
      mismatched++;
      $error("FAIL sat_stall_cnt: observed %0d expected %0d", stall_cnt, SAT);
    end
    compared++;
    for (int p = 0; p < 10; p++) begin
      do_reset("reset_rand");
      for (int i = 0; i < 80; i++)
        step("random", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS core. It replaces the ad-hoc load-use stall logic with one FSM that owns four things: PC/IF-ID write enables, ID/EX bubble insertion, IF-ID flush on taken branch/jump, and whole-pipe freeze while data memory is busy. It sits beside the ID stage and takes hazard inputs from ID, EX and MEM. It also provides a data-memory watchdog and stall/flush performance counters.

## Interface
- TIMEOUT, 16: max consecutive MEM_WAIT cycles before trap (≥2).
- CNT_W, 16: width of performance counters.

- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, bne, sw).
- id_branch_taken  in  1  ID branch compare resolved taken.
- id_jump  in  1  ID instruction is j.
- ex_rt  in  5  rt of instruction in EX.
- ex_memread  in  1  EX instruction is a load.
- mem_req  in  1  MEM stage issues a data-memory access this cycle.
- mem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads a nop.
- idex_bubble  out  1  ID/EX control fields loaded as zero.
- pipe_hold  out  1  ID/EX, EX/MEM, MEM/WB hold their contents.
- pc_src_sel  out  2  00 PC+4, 01 branch target, 10 jump target.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  cycles with pc_write=0 outside reset and TRAP.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1.

## Operation
- States: RUN, LU_STALL, MEM_WAIT, TRAP.
- Load-use hazard (LU): ex_memread && ex_rt≠0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Default outputs: pc_write=1, ifid_write=1, all others 0, pc_src_sel=00.
- Decisions in RUN and LU_STALL are evaluated in priority order:
  - mem_req && !mem_ready: pc_write=0, ifid_write=0, pipe_hold=1. Go to MEM_WAIT and clear wait_cnt.
  - LU: pc_write=0, ifid_write=0, idex_bubble=1. id_branch_taken and id_jump are ignored, because the compare uses stale data. Go to LU_STALL.
  - id_jump: pc_src_sel=10, ifid_flush=1.
  - id_branch_taken: pc_src_sel=01, ifid_flush=1.
  - Otherwise go to / stay in RUN.
- mem_req && mem_ready in the same cycle is a zero-wait access. It causes no freeze, and lower-priority decisions apply in that cycle.
- MEM_WAIT:
  - While !mem_ready: freeze outputs as above, and wait_cnt increments.
  - On mem_ready: freeze is released in that cycle and the RUN decision list is applied combinationally. The next state comes from that list.
  - If wait_cnt==TIMEOUT-1 && !mem_ready: set mem_timeout and go to TRAP.
- TRAP: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=1. Only RST exits.
- Counters saturate at all-ones (no wrap). stall_cnt increments once per cycle even when several stall causes coincide.

## Timing
- All control outputs are Mealy-combinational from state and current inputs, and valid within the same cycle.
- State, wait_cnt, counters and mem_timeout are registered and update on the rising CLK edge.
- Load-use costs exactly 1 bubble cycle. A branch behind a load resolves in the cycle after LU_STALL.
- Taken branch/jump costs 1 flushed slot, with no state change.
- MEM_WAIT of N cycles (mem_ready on the N+1th cycle after entry) freezes the pipe for N+1 cycles total, including the entry cycle.
- While RST is high: pc_write=0, ifid_write=0, all other outputs 0, state=RUN, counters=0, mem_timeout=0.
- RST asserted mid-MEM_WAIT or in TRAP: the same reset values apply immediately (asynchronous).
- First cycle after RST deasserts: state is RUN and default outputs apply.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state encodings (RUN=2'd0, LU_STALL=2'd1, MEM_WAIT=2'd2, TRAP=2'd3);
  - pc_src_sel constants PCSRC_SEQ, PCSRC_BR, PCSRC_JMP.
- One sub-module, mem_wait_timer. It contains wait_cnt, the TIMEOUT compare and the sticky mem_timeout, with clear/enable inputs from the FSM.
- Counters stay inline.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> one cycle of pc_write=0, idex_bubble=1; next cycle pc_write=1; stall_cnt=1.
- r0 and rt-unused cases: ex_rt=0=id_rs -> no stall. ex_rt=7=id_rt with id_uses_rt=0 -> no stall.
- Branch after load: LU and id_branch_taken=1 in the same cycle -> pc_src_sel=00, ifid_flush=0. Next cycle, taken again -> pc_src_sel=01, ifid_flush=1, flush_cnt=1.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> pipe_hold=1 for 3 cycles, released in the ready cycle, stall_cnt=3.
- Watchdog: TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after 4th MEM_WAIT cycle; TRAP outputs persist; RST clears all outputs to reset values.
- Counter saturation: CNT_W=4 and 20 consecutive load-use stalls -> stall_cnt stops at 15.
